// File: rtl/cpu_sequencer_if.sv
// Bus bundle between cpu_sequencer and the instruction memory, register file,
// ALU and data memory it controls.
interface cpu_sequencer_if #(
  parameter int PC_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_data;
  logic [4:0]      rf_ra1;
  logic [4:0]      rf_ra2;
  logic [31:0]     rf_rd1;
  logic [31:0]     rf_rd2;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [31:0]     rf_wd;
  logic [5:0]      alu_op;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [31:0]     alu_y;
  logic            dmem_req;
  logic            dmem_we;
  logic [PC_W-1:0] dmem_addr;
  logic [31:0]     dmem_wdata;
  logic            dmem_ack;
  logic [31:0]     dmem_rdata;
  logic            instr_done;
  logic            halted;

  modport master (
    output imem_req, imem_addr, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd,
           alu_op, alu_a, alu_b, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           instr_done, halted,
    input  imem_ack, imem_data, rf_rd1, rf_rd2, alu_y, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd,
           alu_op, alu_a, alu_b, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           instr_done, halted,
    output imem_ack, imem_data, rf_rd1, rf_rd2, alu_y, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: fetch, decode, execute, memory, writeback.
// Owns the PC; every bus output is a flop computed from the next state.
module cpu_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.master bus
);

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_STORE = 6'd3;
  localparam logic [5:0] OP_LOAD  = 6'd4;
  localparam logic [5:0] OP_MOVE  = 6'd5;
  localparam logic [5:0] OP_MOVEI = 6'd16;
  localparam logic [5:0] OP_SLI   = 6'd17;
  localparam logic [5:0] OP_SRI   = 6'd18;
  localparam logic [5:0] OP_ADDI  = 6'd19;
  localparam logic [5:0] OP_SUBI  = 6'd20;
  localparam logic [5:0] OP_JUMP  = 6'd21;
  localparam logic [5:0] OP_BRA   = 6'd22;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  function automatic logic op_is_legal(input logic [5:0] op_f);
    return (op_f <= OP_BRA);
  endfunction

  function automatic logic op_is_mem(input logic [5:0] op_f);
    return (op_f == OP_LOAD) || (op_f == OP_STORE);
  endfunction

  function automatic logic op_writes_rf(input logic [5:0] op_f);
    return (op_f != OP_NOP) && (op_f != OP_STORE) && (op_f != OP_JUMP) && (op_f != OP_BRA);
  endfunction

  function automatic logic [5:0] exec_alu_op(input logic [5:0] op_f);
    case (op_f)
      OP_LOAD, OP_STORE: return OP_ADD;
      OP_MOVE, OP_MOVEI: return OP_NOP;
      default:           return op_f;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d, a_q, a_d, b_q, b_d, s_q, s_d, r_q, r_d;

  logic            imem_req_q, imem_req_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;
  logic [4:0]      rf_ra1_q, rf_ra1_d, rf_ra2_q, rf_ra2_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_wa_q, rf_wa_d;
  logic [31:0]     rf_wd_q, rf_wd_d;
  logic [5:0]      alu_op_q, alu_op_d;
  logic [31:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic            dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [PC_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]     dmem_wdata_q, dmem_wdata_d;
  logic            instr_done_q, instr_done_d;
  logic            halted_q, halted_d;

  logic [5:0]        op;
  logic [31:0]       simm, zimm;
  logic [PC_W+25:0]  jump_ext;
  logic [PC_W+31:0]  simm_ext;
  logic [PC_W-1:0]   pc_inc, pc_next;

  assign op       = ir_q[31:26];
  assign simm     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm     = {16'd0, ir_q[15:0]};
  assign jump_ext = {{PC_W{1'b0}}, ir_q[25:0]};
  assign simm_ext = {{PC_W{simm[31]}}, simm};
  assign pc_inc   = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  // Branch reads A, which was latched in DECODE, so the target is ready by EXEC.
  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_JUMP: pc_next = jump_ext[PC_W-1:0];
      OP_BRA: begin
        if (a_q != 32'd0) pc_next = pc_inc + simm_ext[PC_W-1:0];
        else              pc_next = pc_inc;
      end
      default: pc_next = pc_inc;
    endcase
  end

  // Next-state, datapath latches, and output values keyed on the state being entered.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        a_d = bus.rf_rd1;
        s_d = bus.rf_rd2;
        case (op)
          OP_ADDI, OP_SUBI, OP_LOAD, OP_STORE: b_d = simm;
          OP_SLI, OP_SRI:                      b_d = zimm;
          default:                             b_d = bus.rf_rd2;
        endcase
        if (op_is_legal(op)) state_d = S_EXEC;
        else                 state_d = S_HALT;
      end
      S_EXEC: begin
        case (op)
          OP_MOVE:  r_d = a_q;
          OP_MOVEI: r_d = simm;
          default:  r_d = bus.alu_y;
        endcase
        if (op_is_mem(op)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
          pc_d    = pc_next;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (op == OP_LOAD) r_d = bus.dmem_rdata;
          else               r_d = r_q;
          state_d = S_WB;
          pc_d    = pc_next;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    imem_req_d   = 1'b0;
    imem_addr_d  = {PC_W{1'b0}};
    rf_ra1_d     = 5'd0;
    rf_ra2_d     = 5'd0;
    rf_we_d      = 1'b0;
    rf_wa_d      = 5'd0;
    rf_wd_d      = 32'd0;
    alu_op_d     = 6'd0;
    alu_a_d      = 32'd0;
    alu_b_d      = 32'd0;
    dmem_req_d   = 1'b0;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = {PC_W{1'b0}};
    dmem_wdata_d = 32'd0;
    instr_done_d = 1'b0;
    halted_d     = 1'b0;
    case (state_d)
      S_FETCH: begin
        imem_req_d  = 1'b1;
        imem_addr_d = pc_d;
      end
      S_DECODE: begin
        rf_ra1_d = ir_d[20:16];
        if (ir_d[31:26] == OP_STORE) rf_ra2_d = ir_d[25:21];
        else                         rf_ra2_d = ir_d[15:11];
      end
      S_EXEC: begin
        alu_op_d = exec_alu_op(op);
        alu_a_d  = a_d;
        alu_b_d  = b_d;
      end
      S_MEM: begin
        dmem_req_d   = 1'b1;
        dmem_we_d    = (op == OP_STORE);
        dmem_addr_d  = r_d[PC_W-1:0];
        dmem_wdata_d = s_d;
      end
      S_WB: begin
        instr_done_d = 1'b1;
        if (op_writes_rf(op)) begin
          rf_we_d = 1'b1;
          rf_wa_d = ir_q[25:21];
          rf_wd_d = r_d;
        end else begin
          rf_we_d = 1'b0;
        end
      end
      S_HALT:  halted_d = 1'b1;
      default: halted_d = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= 32'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      s_q          <= 32'd0;
      r_q          <= 32'd0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= {PC_W{1'b0}};
      rf_ra1_q     <= 5'd0;
      rf_ra2_q     <= 5'd0;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= 5'd0;
      rf_wd_q      <= 32'd0;
      alu_op_q     <= 6'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= {PC_W{1'b0}};
      dmem_wdata_q <= 32'd0;
      instr_done_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      s_q          <= s_d;
      r_q          <= r_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      rf_ra1_q     <= rf_ra1_d;
      rf_ra2_q     <= rf_ra2_d;
      rf_we_q      <= rf_we_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      instr_done_q <= instr_done_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.rf_ra1     = rf_ra1_q;
  assign bus.rf_ra2     = rf_ra2_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_wa      = rf_wa_q;
  assign bus.rf_wd      = rf_wd_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.instr_done = instr_done_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed cases plus random legal
// instructions checked cycle by cycle against an instruction-level model.
module tb_cpu_sequencer;
  localparam int PC_W = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cpu_sequencer_if #(.PC_W(PC_W)) bus ();

  cpu_sequencer #(.PC_W(PC_W), .RESET_PC(32'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] cur_instr;
  int          iwait, dwait, icnt, dcnt;
  bit          stray_en;
  logic [31:0] model_pc;

  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      6'd1, 6'd19: return a + b;
      6'd2, 6'd20: return a - b;
      6'd6:  return {31'd0, $signed(a) >= $signed(b)};
      6'd7:  return {31'd0, $signed(a) <= $signed(b)};
      6'd8:  return {31'd0, $signed(a) >  $signed(b)};
      6'd9:  return {31'd0, $signed(a) <  $signed(b)};
      6'd10: return {31'd0, a == b};
      6'd11: return {31'd0, a != b};
      6'd12: return a & b;
      6'd13: return a | b;
      6'd14: return a ^ b;
      6'd15: return ~a;
      6'd17: return a << b[4:0];
      6'd18: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] dmem_rd(input logic [31:0] addr);
    if (dmem.exists(addr)) return dmem[addr];
    return addr ^ 32'h5A5A_1234;
  endfunction

  assign bus.rf_rd1 = rf[bus.rf_ra1];
  assign bus.rf_rd2 = rf[bus.rf_ra2];
  assign bus.alu_y  = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory and register-file side, driven once per cycle at the falling edge.
  task automatic respond();
    if (bus.rf_we) rf[bus.rf_wa] = bus.rf_wd;
    if (bus.imem_req) begin
      if (icnt < iwait) begin
        icnt++;
        bus.imem_ack  = 1'b0;
        bus.imem_data = $urandom;
      end else begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = cur_instr;
      end
    end else begin
      icnt = 0;
      bus.imem_ack  = stray_en && ($urandom_range(0, 3) == 0);
      bus.imem_data = $urandom;
    end
    if (bus.dmem_req) begin
      if (dcnt < dwait) begin
        dcnt++;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
      end else begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = dmem_rd(bus.dmem_addr);
        if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
      end
    end else begin
      dcnt = 0;
      bus.dmem_ack   = stray_en && ($urandom_range(0, 3) == 0);
      bus.dmem_rdata = $urandom;
    end
  endtask

  // Runs one instruction; t0 = 1 when an IDLE cycle (just after reset) comes first.
  task automatic exec_instr(input logic [31:0] instr, input int iw, input int dw, input int t0);
    logic [5:0]  op, aop;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] simm, zimm, a, b, s, res, npc, ea;
    bit          mem, wr, done;
    int          n, exec_n, mem_lo, mem_hi, wb_n;
    op   = instr[31:26];
    rd   = instr[25:21];
    rs1  = instr[20:16];
    rs2  = instr[15:11];
    simm = {{16{instr[15]}}, instr[15:0]};
    zimm = {16'd0, instr[15:0]};
    a    = rf[rs1];
    s    = rf[rd];
    case (op)
      6'd3, 6'd4, 6'd19, 6'd20: b = simm;
      6'd17, 6'd18:             b = zimm;
      default:                  b = rf[rs2];
    endcase
    mem = (op == 6'd3) || (op == 6'd4);
    aop = mem ? 6'd1 : ((op == 6'd5 || op == 6'd16) ? 6'd0 : op);
    ea  = a + simm;
    case (op)
      6'd5:    res = a;
      6'd16:   res = simm;
      6'd4:    res = dmem_rd(ea);
      default: res = alu_fn(op, a, b);
    endcase
    wr = !(op inside {6'd0, 6'd3, 6'd21, 6'd22});
    case (op)
      6'd21:   npc = {6'd0, instr[25:0]};
      6'd22:   npc = (a != 32'd0) ? model_pc + 32'd1 + simm : model_pc + 32'd1;
      default: npc = model_pc + 32'd1;
    endcase
    exec_n = t0 + iw + 3;
    mem_lo = exec_n + 1;
    mem_hi = mem ? exec_n + 1 + dw : exec_n;
    wb_n   = mem_hi + 1;

    cur_instr = instr;
    iwait = iw;
    dwait = dw;
    icnt  = 0;
    dcnt  = 0;
    n     = 0;
    done  = 1'b0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      chk("imem_req", bus.imem_req, (n > t0) && (n <= t0 + iw + 1));
      if (bus.imem_req) chk("imem_addr", bus.imem_addr, model_pc);
      chk("alu_op", bus.alu_op, (n == exec_n) ? aop : 6'd0);
      if (n == exec_n) begin
        chk("alu_a", bus.alu_a, a);
        chk("alu_b", bus.alu_b, b);
      end
      chk("dmem_req", bus.dmem_req, (n >= mem_lo) && (n <= mem_hi));
      if (bus.dmem_req) begin
        chk("dmem_addr", bus.dmem_addr, ea);
        chk("dmem_we", bus.dmem_we, op == 6'd3);
        if (op == 6'd3) chk("dmem_wdata", bus.dmem_wdata, s);
      end
      chk("instr_done", bus.instr_done, n == wb_n);
      chk("halted", bus.halted, 1'b0);
      if (bus.instr_done) begin
        done = 1'b1;
        chk("rf_we", bus.rf_we, wr);
        if (wr) begin
          chk("rf_wa", bus.rf_wa, rd);
          chk("rf_wd", bus.rf_wd, res);
        end
      end else begin
        chk("rf_we_idle", bus.rf_we, 1'b0);
      end
      respond();
    end
    chk("retired", done, 1'b1);
    model_pc = npc;
  endtask

  initial begin
    logic [31:0] rnd;
    reset          = 1'b1;
    stray_en       = 1'b0;
    iwait          = 0;
    dwait          = 0;
    icnt           = 0;
    dcnt           = 0;
    cur_instr      = 32'd0;
    bus.imem_ack   = 1'b0;
    bus.imem_data  = 32'd0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
    model_pc       = 32'd0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", bus.imem_req, 1'b0);
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
    chk("rst_dmem_req", bus.dmem_req, 1'b0);
    chk("rst_dmem_addr", bus.dmem_addr, 32'd0);
    chk("rst_rf_we", bus.rf_we, 1'b0);
    chk("rst_rf_wd", bus.rf_wd, 32'd0);
    chk("rst_alu_op", bus.alu_op, 6'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_instr_done", bus.instr_done, 1'b0);
    chk("rst_halted", bus.halted, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // MOVEI r1,5 right after reset: IDLE + 4 cycles
    exec_instr({6'd16, 5'd1, 5'd0, 16'd5}, 0, 0, 1);
    // ADD r3,r1,r2 with 7 + 9
    rf[1] = 32'd7;
    rf[2] = 32'd9;
    exec_instr({6'd1, 5'd3, 5'd1, 5'd2, 11'd0}, 0, 0, 0);
    // LOAD r4,[r1-1] with three data wait cycles
    rf[1] = 32'h10;
    exec_instr({6'd4, 5'd4, 5'd1, 16'hFFFF}, 0, 3, 0);
    // Branch taken and not taken from pc 10, then an absolute jump
    rf[5] = 32'd1;
    rf[6] = 32'd0;
    exec_instr({6'd21, 26'd10}, 1, 0, 0);
    exec_instr({6'd22, 5'd0, 5'd5, 16'hFFFD}, 0, 0, 0);
    chk("bra_taken_pc", model_pc, 32'd8);
    exec_instr({6'd21, 26'd10}, 0, 0, 0);
    exec_instr({6'd22, 5'd0, 5'd6, 16'hFFFD}, 0, 0, 0);
    exec_instr({6'd21, 26'h40}, 0, 0, 0);
    exec_instr({6'd0, 26'd0}, 0, 0, 0);

    stray_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      rnd = $urandom;
      exec_instr({6'($urandom_range(0, 22)), rnd[25:0]}, $urandom_range(0, 2),
                 $urandom_range(0, 3), 0);
    end
    stray_en = 1'b0;

    // Illegal opcode (ADDF) halts two cycles after the fetch ack
    cur_instr = {6'd23, 26'h123};
    iwait = 0;
    icnt  = 0;
    @(negedge clk);
    chk("halt_fetch_req", bus.imem_req, 1'b1);
    chk("halt_fetch_addr", bus.imem_addr, model_pc);
    respond();
    @(negedge clk);
    chk("halt_decode", bus.halted, 1'b0);
    respond();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("halted", bus.halted, 1'b1);
      chk("halt_imem_req", bus.imem_req, 1'b0);
      chk("halt_rf_we", bus.rf_we, 1'b0);
      chk("halt_dmem_req", bus.dmem_req, 1'b0);
      respond();
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("halt_cleared", bus.halted, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_pc = 32'd0;
    exec_instr({6'd16, 5'd2, 5'd0, 16'h8001}, 0, 0, 1);

    // Reset in the middle of a STORE's memory phase
    rf[7] = 32'h100;
    rf[8] = 32'hCAFE;
    cur_instr = {6'd3, 5'd8, 5'd7, 16'h0004};
    iwait = 0;
    dwait = 10;
    icnt  = 0;
    dcnt  = 0;
    for (int k = 0; k < 8 && !bus.dmem_req; k++) begin
      @(negedge clk);
      respond();
    end
    chk("store_dmem_req", bus.dmem_req, 1'b1);
    chk("store_dmem_addr", bus.dmem_addr, 32'h104);
    #2 reset = 1'b1;
    #1;
    chk("async_dmem_req", bus.dmem_req, 1'b0);
    chk("async_dmem_we", bus.dmem_we, 1'b0);
    chk("async_dmem_addr", bus.dmem_addr, 32'd0);
    chk("async_imem_req", bus.imem_req, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_pc = 32'd0;
    exec_instr({6'd5, 5'd9, 5'd7, 16'd0}, 0, 0, 1);
    exec_instr({6'd4, 5'd10, 5'd7, 16'h0004}, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
